// File: rtl/pkt_rx_pkg.sv
// Shared types and helpers for the packet capture writer.
package pkt_rx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    DONE = 2'd2,
    DROP = 2'd3
  } state_t;

  localparam int DEFAULT_MAX_PKT_WORDS = 380;

  // Ring index increment: size-1 wraps back to 0.
  function automatic logic [31:0] wrap_inc(input logic [31:0] idx, input logic [31:0] size);
    return (idx + 32'd1 >= size) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/pkt_rx_writer.sv
// Captures an Avalon-ST packet stream into an SDRAM ring through an Avalon-MM
// write host and publishes a descriptor for every committed packet.
module pkt_rx_writer
  import pkt_rx_pkg::*;
#(
  parameter int PTR_W         = 16,
  parameter int MAX_PKT_WORDS = DEFAULT_MAX_PKT_WORDS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [31:0]      buf_base,
  input  logic [PTR_W-1:0] buf_words,
  input  logic [PTR_W-1:0] rd_ptr,
  input  logic [31:0]      st_data,
  input  logic             st_valid,
  input  logic             st_sop,
  input  logic             st_eop,
  input  logic [1:0]       st_empty,
  output logic             st_ready,
  output logic [31:0]      avm_address,
  output logic [31:0]      avm_writedata,
  output logic             avm_write,
  output logic [15:0]      avm_burstcount,
  input  logic             avm_waitrequest,
  output logic             pkt_valid,
  output logic [31:0]      pkt_begin,
  output logic [31:0]      pkt_end,
  output logic [15:0]      pkt_bytes,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [31:0]      pkt_count,
  output logic [31:0]      drop_count
);

  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [PTR_W-1:0] idx);
    return base + (32'(idx) << 2);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] idx,
                                               input logic [PTR_W-1:0] size);
    return PTR_W'(wrap_inc(32'(idx), 32'(size)));
  endfunction

  state_t           state, state_next;
  logic [PTR_W-1:0] cur_ptr, pkt_start, write_idx;
  logic [15:0]      word_cnt;
  logic [1:0]       last_empty;
  logic             stall, wr_done, beat;
  logic             start_full, cont_full, too_long;
  logic             do_write, do_start, do_drop, do_commit;

  assign avm_burstcount = 16'd1;
  assign stall          = avm_write && avm_waitrequest;
  assign wr_done        = avm_write && !avm_waitrequest;

  // IDLE also waits out a stalled write: a drop can leave one in flight and
  // its address/data registers must not be overwritten by a new packet.
  assign st_ready = reset && ((state == DROP) ||
                              (((state == IDLE) || (state == DATA)) && !stall));
  assign beat       = st_valid && st_ready;
  assign start_full = (ptr_next(wr_ptr, buf_words) == rd_ptr);
  assign cont_full  = (ptr_next(cur_ptr, buf_words) == rd_ptr);
  assign too_long   = (word_cnt >= 16'(MAX_PKT_WORDS));

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_next = state;
    do_write   = 1'b0;
    do_start   = 1'b0;
    do_drop    = 1'b0;
    do_commit  = 1'b0;
    write_idx  = cur_ptr;
    unique case (state)
      IDLE: begin
        if (beat && st_sop && enable) begin
          if (start_full) begin
            do_drop    = 1'b1;
            state_next = st_eop ? IDLE : DROP;
          end else begin
            do_start   = 1'b1;
            do_write   = 1'b1;
            write_idx  = wr_ptr;
            state_next = st_eop ? DONE : DATA;
          end
        end
      end
      DATA: begin
        if (beat) begin
          if (st_sop) begin
            // Abandon the open packet; the sop restarts at the committed index.
            do_drop = 1'b1;
            if (enable && !start_full) begin
              do_start   = 1'b1;
              do_write   = 1'b1;
              write_idx  = wr_ptr;
              state_next = st_eop ? DONE : DATA;
            end else begin
              state_next = st_eop ? IDLE : DROP;
            end
          end else if (cont_full || too_long) begin
            do_drop    = 1'b1;
            state_next = st_eop ? IDLE : DROP;
          end else begin
            do_write   = 1'b1;
            state_next = st_eop ? DONE : DATA;
          end
        end
      end
      DONE: begin
        if (wr_done) begin
          do_commit  = 1'b1;
          state_next = IDLE;
        end
      end
      DROP: begin
        if (beat && st_eop) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_ptr       <= '0;
      wr_ptr        <= '0;
      pkt_start     <= '0;
      word_cnt      <= '0;
      last_empty    <= '0;
      avm_address   <= '0;
      avm_writedata <= '0;
      avm_write     <= 1'b0;
      pkt_valid     <= 1'b0;
      pkt_begin     <= '0;
      pkt_end       <= '0;
      pkt_bytes     <= '0;
      pkt_count     <= '0;
      drop_count    <= '0;
    end else begin
      pkt_valid <= 1'b0;

      if (do_write) begin
        avm_address   <= word_addr(buf_base, write_idx);
        avm_writedata <= st_data;
        avm_write     <= 1'b1;
        cur_ptr       <= ptr_next(write_idx, buf_words);
      end else begin
        if (wr_done) avm_write <= 1'b0;
        if (do_drop) cur_ptr <= wr_ptr;
      end

      if (do_start) begin
        pkt_start <= wr_ptr;
        word_cnt  <= 16'd1;
      end else if (do_write) begin
        word_cnt <= word_cnt + 16'd1;
      end

      if (do_write && st_eop) last_empty <= st_empty;

      if (do_drop && (drop_count != 32'hFFFF_FFFF)) drop_count <= drop_count + 32'd1;

      if (do_commit) begin
        pkt_valid <= 1'b1;
        pkt_begin <= word_addr(buf_base, pkt_start);
        pkt_end   <= word_addr(buf_base, cur_ptr);
        pkt_bytes <= (word_cnt << 2) - 16'(last_empty);
        wr_ptr    <= cur_ptr;
        if (pkt_count != 32'hFFFF_FFFF) pkt_count <= pkt_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_pkt_rx_writer.sv
// Self-checking bench for pkt_rx_writer: a ring-level packet model predicts
// every SDRAM write and descriptor; directed scenarios pin the model.
module tb_pkt_rx_writer;

  localparam int PTR_W = 16;
  localparam int MAXW  = 380;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic [31:0]      buf_base;
  logic [PTR_W-1:0] buf_words;
  logic [PTR_W-1:0] rd_ptr;
  logic [31:0]      st_data;
  logic             st_valid, st_sop, st_eop;
  logic [1:0]       st_empty;
  logic             st_ready;
  logic [31:0]      avm_address, avm_writedata;
  logic             avm_write;
  logic [15:0]      avm_burstcount;
  logic             avm_waitrequest;
  logic             pkt_valid;
  logic [31:0]      pkt_begin, pkt_end;
  logic [15:0]      pkt_bytes;
  logic [PTR_W-1:0] wr_ptr;
  logic [31:0]      pkt_count, drop_count;

  pkt_rx_writer #(.PTR_W(PTR_W), .MAX_PKT_WORDS(MAXW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .buf_base(buf_base),
    .buf_words(buf_words), .rd_ptr(rd_ptr), .st_data(st_data),
    .st_valid(st_valid), .st_sop(st_sop), .st_eop(st_eop), .st_empty(st_empty),
    .st_ready(st_ready), .avm_address(avm_address), .avm_writedata(avm_writedata),
    .avm_write(avm_write), .avm_burstcount(avm_burstcount),
    .avm_waitrequest(avm_waitrequest), .pkt_valid(pkt_valid),
    .pkt_begin(pkt_begin), .pkt_end(pkt_end), .pkt_bytes(pkt_bytes),
    .wr_ptr(wr_ptr), .pkt_count(pkt_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
  typedef struct { logic [31:0] pbeg; logic [31:0] pend; logic [31:0] bytes; logic [31:0] wr; } desc_t;

  int          checks = 0;
  int          failures = 0;
  wr_t         exp_wr[$];
  desc_t       exp_desc[$];
  logic [31:0] wr_log[$];
  int          m_wr = 0, m_pkts = 0, m_drops = 0, pkt_id = 0;
  bit          m_open = 1'b0;
  logic [31:0] last_begin = '0, last_end = '0, last_bytes = '0;
  bit          stall_en = 1'b0;
  logic [31:0] stall_addr = '0;
  int          stall_cnt = 0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_addr = '0, prev_data = '0;
  wr_t         got_w;
  desc_t       got_d;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ring_addr(input int idx);
    return buf_base + 32'((idx % int'(buf_words)) * 4);
  endfunction

  function automatic logic [31:0] beat_data(input int id, input int k);
    return (32'(id) << 16) | 32'(k);
  endfunction

  // Slave stall: hold waitrequest for 5 cycles on the write to stall_addr.
  always @(posedge clk) begin
    #1;
    if (stall_en && avm_write && (avm_address == stall_addr) && (stall_cnt < 5)) begin
      avm_waitrequest = 1'b1;
      stall_cnt++;
    end else begin
      avm_waitrequest = 1'b0;
    end
  end

  // Compare process: every completed write and every descriptor against the model.
  always @(negedge clk) begin
    if (reset) begin
      if (prev_stall) begin
        check("hold_write", 32'(avm_write), 32'd1);
        check("hold_addr", avm_address, prev_addr);
        check("hold_data", avm_writedata, prev_data);
      end
      if (stall_en && avm_write && avm_waitrequest)
        check("ready_in_stall", 32'(st_ready), 32'd0);
      if (avm_write && !avm_waitrequest) begin
        wr_log.push_back(avm_address);
        if (exp_wr.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write addr=%h data=%h expected=none", avm_address, avm_writedata);
        end else begin
          got_w = exp_wr.pop_front();
          check("write_addr", avm_address, got_w.addr);
          check("write_data", avm_writedata, got_w.data);
        end
      end
      if (pkt_valid) begin
        last_begin = pkt_begin;
        last_end   = pkt_end;
        last_bytes = 32'(pkt_bytes);
        if (exp_desc.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_descriptor begin=%h expected=none", pkt_begin);
        end else begin
          got_d = exp_desc.pop_front();
          check("pkt_begin", pkt_begin, got_d.pbeg);
          check("pkt_end", pkt_end, got_d.pend);
          check("pkt_bytes", 32'(pkt_bytes), got_d.bytes);
          check("desc_wr_ptr", 32'(wr_ptr), got_d.wr);
        end
      end
      prev_stall = avm_write && avm_waitrequest;
      prev_addr  = avm_address;
      prev_data  = avm_writedata;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input logic [31:0] d, input bit sop, input bit eop,
                            input logic [1:0] emp, output int waited);
    st_data  = d;
    st_sop   = sop;
    st_eop   = eop;
    st_empty = eop ? emp : 2'd0;
    st_valid = 1'b1;
    waited   = -1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (st_ready) begin
        waited = i;
        break;
      end
    end
    if (waited < 0) begin
      checks++;
      failures++;
      $display("FAIL beat_accept actual=timeout expected=accepted data=%h", d);
    end
    @(posedge clk);
    #1;
    st_valid = 1'b0;
    st_sop   = 1'b0;
    st_eop   = 1'b0;
  endtask

  // Model: a packet of n words fits until the word that would make the ring
  // full (one slot kept free) or the word past MAXW; earlier words are written.
  task automatic send_pkt(input int n, input bit term, input logic [1:0] emp);
    int  size, free, d, w, nxt;
    bit  live;
    wr_t   e;
    desc_t ds;
    size = int'(buf_words);
    if (m_open) begin
      m_drops++;
      m_open = 1'b0;
    end
    pkt_id++;
    live = enable;
    d    = n + 1;
    if (live) begin
      free = (int'(rd_ptr) - m_wr - 1 + size) % size;
      d    = (free + 1 < MAXW + 1) ? free + 1 : MAXW + 1;
      for (int k = 1; k <= n && k < d; k++) begin
        e.addr = ring_addr(m_wr + k - 1);
        e.data = beat_data(pkt_id, k);
        exp_wr.push_back(e);
      end
      if (n >= d) begin
        m_drops++;
      end else if (term) begin
        nxt      = (m_wr + n) % size;
        ds.pbeg  = ring_addr(m_wr);
        ds.pend  = ring_addr(nxt);
        ds.bytes = 32'(4 * n - int'(emp));
        ds.wr    = 32'(nxt);
        exp_desc.push_back(ds);
        m_wr = nxt;
        m_pkts++;
      end else begin
        m_open = 1'b1;
      end
    end
    for (int k = 1; k <= n; k++) begin
      drive_beat(beat_data(pkt_id, k), k == 1, term && (k == n), emp, w);
      if (live && k > d) check("drop_ready", 32'(w), 32'd0);
    end
  endtask

  task automatic wait_quiet();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3000 && (exp_wr.size() != 0 || exp_desc.size() != 0); i++)
      @(negedge clk);
    repeat (3) @(negedge clk);
    check("queues_drained", 32'(exp_wr.size() + exp_desc.size()), 32'd0);
    check("model_pkt_count", pkt_count, 32'(m_pkts));
    check("model_drop_count", drop_count, 32'(m_drops));
    check("model_wr_ptr", 32'(wr_ptr), 32'(m_wr));
    sync();
  endtask

  task automatic assert_reset();
    reset = 1'b0;
    exp_wr.delete();
    exp_desc.delete();
    m_wr = 0; m_pkts = 0; m_drops = 0; m_open = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_st_ready", 32'(st_ready), 32'd0);
    check("rst_avm_write", 32'(avm_write), 32'd0);
    check("rst_avm_address", avm_address, 32'd0);
    check("rst_burstcount", 32'(avm_burstcount), 32'd1);
    check("rst_pkt_valid", 32'(pkt_valid), 32'd0);
    check("rst_pkt_begin", pkt_begin, 32'd0);
    check("rst_pkt_bytes", 32'(pkt_bytes), 32'd0);
    check("rst_wr_ptr", 32'(wr_ptr), 32'd0);
    check("rst_pkt_count", pkt_count, 32'd0);
    check("rst_drop_count", drop_count, 32'd0);
    sync();
    reset = 1'b1;
    sync();
    wr_log.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; enable = 1'b1; buf_base = 32'h1000_0000; buf_words = 16'd64;
    rd_ptr = '0; st_data = '0; st_valid = 1'b0; st_sop = 1'b0; st_eop = 1'b0;
    st_empty = '0; avm_waitrequest = 1'b0;
    assert_reset();

    // Basic 3-beat packet, 2 empty bytes.
    send_pkt(3, 1'b1, 2'd2);
    wait_quiet();
    check("t1_addr0", wr_log[0], 32'h1000_0000);
    check("t1_addr2", wr_log[2], 32'h1000_0008);
    check("t1_begin", last_begin, 32'h1000_0000);
    check("t1_end", last_end, 32'h1000_000C);
    check("t1_bytes", last_bytes, 32'd10);
    check("t1_wr_ptr", 32'(wr_ptr), 32'd3);

    // sop with enable low is discarded without counting.
    enable = 1'b0;
    send_pkt(2, 1'b1, 2'd0);
    enable = 1'b1;
    wait_quiet();
    check("t1_gated_pkts", pkt_count, 32'd1);

    // Slave stall of 5 cycles on the 2nd write.
    stall_addr = 32'h1000_0010;
    stall_cnt  = 0;
    stall_en   = 1'b1;
    send_pkt(4, 1'b1, 2'd0);
    wait_quiet();
    stall_en = 1'b0;
    check("t2_stall_cycles", 32'(stall_cnt), 32'd5);
    check("t2_begin", last_begin, 32'h1000_000C);
    check("t2_end", last_end, 32'h1000_001C);
    check("t2_bytes", last_bytes, 32'd16);

    // Ring wrap: wr_ptr 62 of 64, 4 words.
    assert_reset();
    send_pkt(62, 1'b1, 2'd0);
    wait_quiet();
    rd_ptr = 16'd10;
    wr_log.delete();
    send_pkt(4, 1'b1, 2'd3);
    wait_quiet();
    check("t3_addr0", wr_log[0], 32'h1000_00F8);
    check("t3_addr1", wr_log[1], 32'h1000_00FC);
    check("t3_addr2", wr_log[2], 32'h1000_0000);
    check("t3_addr3", wr_log[3], 32'h1000_0004);
    check("t3_end", last_end, 32'h1000_0008);
    check("t3_bytes", last_bytes, 32'd13);
    check("t3_wr_ptr", 32'(wr_ptr), 32'd2);

    // Ring full: rd_ptr 3, 5 beats -> 3rd beat dropped.
    rd_ptr = 16'd3;
    assert_reset();
    send_pkt(5, 1'b1, 2'd0);
    wait_quiet();
    check("t4_writes", 32'(wr_log.size()), 32'd2);
    check("t4_drop_count", drop_count, 32'd1);
    check("t4_pkt_count", pkt_count, 32'd0);
    check("t4_wr_ptr", 32'(wr_ptr), 32'd0);

    // Oversize: 381 words dropped, next packet reuses the committed index.
    rd_ptr = '0;
    buf_words = 16'd1024;
    assert_reset();
    send_pkt(5, 1'b1, 2'd0);
    send_pkt(381, 1'b1, 2'd0);
    wait_quiet();
    check("t5_drop_count", drop_count, 32'd1);
    send_pkt(2, 1'b1, 2'd0);
    wait_quiet();
    check("t5_begin", last_begin, 32'h1000_0014);
    check("t5_pkt_count", pkt_count, 32'd2);
    check("t5_wr_ptr", 32'(wr_ptr), 32'd7);

    // Mid-packet sop: the sop+eop beat becomes a 1-word packet.
    buf_words = 16'd64;
    assert_reset();
    send_pkt(2, 1'b0, 2'd0);
    send_pkt(1, 1'b1, 2'd1);
    wait_quiet();
    check("t6_drop_count", drop_count, 32'd1);
    check("t6_pkt_count", pkt_count, 32'd1);
    check("t6_bytes", last_bytes, 32'd3);
    check("t6_begin", last_begin, 32'h1000_0000);

    // Reset in the middle of DATA, then a fresh packet from IDLE.
    send_pkt(3, 1'b0, 2'd0);
    assert_reset();
    send_pkt(1, 1'b1, 2'd0);
    wait_quiet();
    check("t7_pkt_count", pkt_count, 32'd1);
    check("t7_begin", last_begin, 32'h1000_0000);
    check("t7_wr_ptr", 32'(wr_ptr), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pkt_rx_writer.md
Name: pkt_rx_writer

Overview:
- Upstream capture stage: takes a 32-bit Avalon-ST packet stream from the Ethernet MAC and writes each packet, word by word, into a circular buffer in SDRAM through an Avalon-MM write host.
- After the last word of a packet is written, it publishes a one-cycle descriptor (pkt_begin, pkt_end, length). The descriptor feeds the capture block's register bank and raises its new-request path.
- Drops oversize packets, malformed packets and packets that do not fit in the ring, and counts them.

Parameters:
- PTR_W, 16, ring index width in 32-bit words (ring up to 2^PTR_W-1 words)
- MAX_PKT_WORDS, 380, longest accepted packet in words (1518 bytes rounded up)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- enable  in  1  accept new packets when high
- buf_base  in  32  ring byte base address, word aligned
- buf_words  in  PTR_W  ring size in words, >=2, static while enable=1
- rd_ptr  in  PTR_W  consumer word index; words before it are free
- st_data  in  32  stream data, first byte in [31:24]
- st_valid  in  1  stream beat valid
- st_sop  in  1  first beat of packet
- st_eop  in  1  last beat of packet
- st_empty  in  2  unused bytes in eop beat
- st_ready  out  1  beat accepted when st_valid&&st_ready
- avm_address  out  32  write byte address
- avm_writedata  out  32  write data
- avm_write  out  1  write request
- avm_burstcount  out  16  constant 1
- avm_waitrequest  in  1  slave stall
- pkt_valid  out  1  one-cycle descriptor strobe
- pkt_begin  out  32  byte address of first word
- pkt_end  out  32  byte address of next free word (wrapped)
- pkt_bytes  out  16  packet length in bytes
- wr_ptr  out  PTR_W  committed write index
- pkt_count  out  32  committed packets, saturating
- drop_count  out  32  dropped packets, saturating

Behaviour:
- Reset (reset=0, async): state IDLE. wr_ptr, cur_ptr, all counters, pkt_* and avm_write are 0. st_ready=0 during reset. avm_burstcount is always 1.
- States:
  - IDLE: st_ready=1.
    - Non-sop beats are discarded silently.
    - sop beat with enable=1: store pkt_start=wr_ptr and write the beat → DATA, or → DONE if the beat also has eop.
    - sop beat with enable=0: discarded, no count.
  - DATA: st_ready = !avm_write || !avm_waitrequest. Each accepted beat:
    - registers avm_address = buf_base + 4*cur_ptr and avm_writedata;
    - asserts avm_write the next cycle;
    - advances cur_ptr with wrap (buf_words-1 → 0).
    - eop beat → DONE.
  - DONE: st_ready=0. Wait until the last write completes (avm_write && !avm_waitrequest), then for one cycle:
    - pkt_valid=1;
    - pkt_begin = buf_base + 4*pkt_start;
    - pkt_end = buf_base + 4*cur_ptr;
    - pkt_bytes = 4*words - st_empty(eop);
    - wr_ptr <= cur_ptr; pkt_count++.
    - Then → IDLE.
  - DROP: st_ready=1. Discard beats until an eop beat, then → IDLE.
- Drop conditions (checked on each beat before it is written):
  - next cur_ptr == rd_ptr (ring full);
  - word count would exceed MAX_PKT_WORDS;
  - sop arrives while in DATA.
- Drop action:
  - cur_ptr <= wr_ptr (rollback); drop_count++.
  - The offending beat is not written. Any write already in flight completes; it is harmless because the space was never published.
  - Drop beat with eop → IDLE. Mid-packet sop drop → that sop starts a new packet in DATA, pkt_start=wr_ptr. Otherwise → DROP.
- Full rule: one word is always left unused, so wr_ptr==rd_ptr means empty.
- enable falling mid-packet: the current packet completes normally; only new sops are gated.
- avm_write, address and data hold stable while avm_waitrequest=1.
- Latency: beat accepted in cycle N → avm_write high in N+1. eop write accepted in cycle M → pkt_valid in M+1.
- Counters saturate at 32'hFFFF_FFFF.

Decomposition:
- pkt_rx_pkg:
  - state enum (IDLE, DATA, DONE, DROP);
  - function for the wrapped increment of a PTR_W index modulo buf_words;
  - DEFAULT_MAX_PKT_WORDS constant.
- No sub-module. The saturating counter is inlined twice.

Test Plan:
- buf_base=0x1000_0000, buf_words=64, rd_ptr=0, 3-beat packet with st_empty=2 → 3 writes at 0x1000_0000/04/08. Then pkt_valid with pkt_begin=0x1000_0000, pkt_end=0x1000_000C, pkt_bytes=10, wr_ptr=3.
- avm_waitrequest held high 5 cycles on the 2nd write → st_ready low, address/data stable, no lost or duplicated beat, descriptor still correct.
- wr_ptr=62, buf_words=64, 4-beat packet, rd_ptr=10 → addresses at words 62, 63, 0, 1. pkt_end = buf_base+8, wr_ptr=2.
- rd_ptr=3, wr_ptr=0, 5-beat packet → 3rd beat dropped. No pkt_valid, drop_count=1, wr_ptr stays 0, st_ready=1 through eop.
- 381-beat packet → drop at beat 381, drop_count=1. Next 2-beat packet commits starting at the original wr_ptr.
- sop mid-packet, then a 1-beat sop+eop packet → drop_count=1, pkt_count=1, pkt_bytes=4-empty. Assert reset mid-DATA → all outputs 0, state IDLE.
